// File: rtl/mem_arbiter.sv
// Single-port byte-wide RAM arbiter serving MMIO, DCache and ICache transfers.
// Fixed priority io > dc > ic, decided only in IDLE; one byte moves per enabled cycle.
module mem_arbiter #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      readyIn,
    input  logic                      clearIn,
    input  logic [7:0]                memIn,
    output logic [31:0]               memAddr,
    output logic [7:0]                memOut,
    output logic                      readWriteOut,
    input  logic                      icReq,
    input  logic [31-BLOCK_WIDTH:0]   icTag,
    output logic                      icDone,
    output logic [8*BLOCK_SIZE-1:0]   icData,
    input  logic                      dcReq,
    input  logic                      dcWrite,
    input  logic [31-BLOCK_WIDTH:0]   dcTag,
    input  logic [8*BLOCK_SIZE-1:0]   dcWData,
    output logic                      dcDone,
    output logic [8*BLOCK_SIZE-1:0]   dcRData,
    input  logic                      ioReq,
    input  logic                      ioWrite,
    input  logic [1:0]                ioSize,
    input  logic [31:0]               ioAddr,
    input  logic [31:0]               ioWData,
    output logic                      ioDone,
    output logic [31:0]               ioRData
);
    // Counter must reach BLOCK_SIZE itself (the trailing capture cycle of a line read).
    localparam int KW = BLOCK_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {ID_NONE, ID_IC, ID_DC, ID_IO} req_id_t;

    state_t                     state_q, state_d;
    req_id_t                    id_q, id_d;
    logic [KW-1:0]              k_q, k_d;
    logic [KW-1:0]              len_q, len_d;
    logic [31:0]                base_q, base_d;
    logic [BLOCK_SIZE-1:0][7:0] buf_q, buf_d;

    logic [BLOCK_WIDTH-1:0]     k_prev;
    logic [KW-1:0]              io_len;
    logic                       io_legal;

    // Wraps to BLOCK_SIZE-1 when k equals BLOCK_SIZE, which is exactly the last byte slot.
    assign k_prev = k_q[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);

    always_comb begin
        io_legal = 1'b1;
        case (ioSize)
            2'b01:   io_len = KW'(1);
            2'b10:   io_len = KW'(2);
            2'b11:   io_len = KW'(4);
            default: begin
                io_len   = KW'(1);
                io_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        id_d    = id_q;
        k_d     = k_q;
        len_d   = len_q;
        base_d  = base_q;
        buf_d   = buf_q;

        if (readyIn) begin
            case (state_q)
                S_IDLE: begin
                    k_d = '0;
                    if (ioReq && io_legal) begin
                        id_d    = ID_IO;
                        base_d  = ioAddr;
                        len_d   = io_len;
                        buf_d   = '0;
                        if (ioWrite) begin
                            for (int i = 0; i < 4; i++) buf_d[i] = ioWData[8*i +: 8];
                        end
                        state_d = ioWrite ? S_WRITE : S_READ;
                    end else if (dcReq) begin
                        id_d    = ID_DC;
                        base_d  = {dcTag, {BLOCK_WIDTH{1'b0}}};
                        len_d   = KW'(BLOCK_SIZE);
                        buf_d   = dcWrite ? dcWData : '0;
                        state_d = dcWrite ? S_WRITE : S_READ;
                    end else if (icReq && !clearIn) begin
                        id_d    = ID_IC;
                        base_d  = {icTag, {BLOCK_WIDTH{1'b0}}};
                        len_d   = KW'(BLOCK_SIZE);
                        buf_d   = '0;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    // A flush only kills speculative fetches; dc and io-write traffic has side effects.
                    if (clearIn && (id_q == ID_IC || id_q == ID_IO)) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                    end else begin
                        if (k_q != '0) buf_d[k_prev] = memIn;
                        if (k_q == len_q) begin
                            state_d = S_DONE;
                            k_d     = '0;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (k_q == len_q - KW'(1)) begin
                        state_d = S_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: the line buffer is reset along with the control state so no stale line leaks after reset.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q <= S_IDLE;
            id_q    <= ID_NONE;
            k_q     <= '0;
            len_q   <= '0;
            base_q  <= '0;
            buf_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            id_q    <= id_d;
            k_q     <= k_d;
            len_q   <= len_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        memAddr      = '0;
        memOut       = '0;
        readWriteOut = 1'b0;
        case (state_q)
            S_READ: begin
                // While stalled, re-present the byte that the resume cycle will capture.
                if (!readyIn && k_q != '0) memAddr = base_q + 32'(k_prev);
                else if (k_q < len_q)      memAddr = base_q + 32'(k_q);
            end
            S_WRITE: begin
                memAddr      = base_q + 32'(k_q);
                memOut       = buf_q[k_q[BLOCK_WIDTH-1:0]];
                readWriteOut = readyIn;
            end
            default: ;
        endcase
    end

    always_comb begin
        ioRData = '0;
        for (int i = 0; i < 4; i++) begin
            if (KW'(i) < len_q) ioRData[8*i +: 8] = buf_q[i];
        end
    end

    assign icDone  = (state_q == S_DONE) && (id_q == ID_IC);
    assign dcDone  = (state_q == S_DONE) && (id_q == ID_DC);
    assign ioDone  = (state_q == S_DONE) && (id_q == ID_IO);
    assign icData  = buf_q;
    assign dcRData = buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level RAM/arbiter model.
module tb_mem_arbiter;
    localparam int BW = 4;
    localparam int N  = 16;

    logic            clkIn = 1'b0;
    logic            resetIn, readyIn, clearIn;
    logic [7:0]      memIn;
    logic [31:0]     memAddr;
    logic [7:0]      memOut;
    logic            readWriteOut;
    logic            icReq;
    logic [31-BW:0]  icTag;
    logic            icDone;
    logic [8*N-1:0]  icData;
    logic            dcReq, dcWrite;
    logic [31-BW:0]  dcTag;
    logic [8*N-1:0]  dcWData;
    logic            dcDone;
    logic [8*N-1:0]  dcRData;
    logic            ioReq, ioWrite;
    logic [1:0]      ioSize;
    logic [31:0]     ioAddr, ioWData;
    logic            ioDone;
    logic [31:0]     ioRData;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  salt = 8'h00;
    logic [39:0] wr_log[$];
    logic [31:0] addr_trace[$];

    mem_arbiter dut (
        .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
        .memIn(memIn), .memAddr(memAddr), .memOut(memOut), .readWriteOut(readWriteOut),
        .icReq(icReq), .icTag(icTag), .icDone(icDone), .icData(icData),
        .dcReq(dcReq), .dcWrite(dcWrite), .dcTag(dcTag), .dcWData(dcWData),
        .dcDone(dcDone), .dcRData(dcRData),
        .ioReq(ioReq), .ioWrite(ioWrite), .ioSize(ioSize), .ioAddr(ioAddr),
        .ioWData(ioWData), .ioDone(ioDone), .ioRData(ioRData)
    );

    always #5 clkIn = ~clkIn;

    // RAM contents are a pure function of the address; a salt varies them between transactions.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        return (a[7:0] + a[23:16]) ^ salt;
    endfunction

    function automatic logic [8*N-1:0] line_model(input logic [31:0] base);
        logic [8*N-1:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = ram_byte(base + 32'(i));
        return r;
    endfunction

    function automatic logic [31:0] io_read_model(input logic [31:0] a, input int len);
        logic [31:0] r = '0;
        for (int i = 0; i < len; i++) r[8*i +: 8] = ram_byte(a + 32'(i));
        return r;
    endfunction

    always @(posedge clkIn) begin
        memIn <= ram_byte(memAddr);
        if (readWriteOut) wr_log.push_back({memAddr, memOut});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // which: 0 ic, 1 dc, 2 io. cyc = tick count at which done was first seen, -1 on timeout.
    task automatic wait_done(input int which, input int limit, input bit stall,
                             output int cyc, output int rdy_edges, output int others);
        logic [2:0] d;
        cyc = -1; rdy_edges = 0; others = 0;
        addr_trace.delete();
        for (int n = 1; n <= limit; n++) begin
            if (readyIn) rdy_edges++;
            tick();
            addr_trace.push_back(memAddr);
            d = {ioDone, dcDone, icDone};
            for (int j = 0; j < 3; j++) if (d[j] && j != which) others++;
            if (d[which]) begin
                cyc = n;
                break;
            end
            if (stall) readyIn = ($urandom_range(0, 3) != 0);
        end
        readyIn = 1'b1;
    endtask

    task automatic drop_all();
        icReq = 1'b0; dcReq = 1'b0; ioReq = 1'b0; clearIn = 1'b0; readyIn = 1'b1;
    endtask

    task automatic test_reset();
        int cyc, re, oth;
        resetIn = 1'b1; drop_all();
        icTag = '0; dcTag = '0; dcWrite = 1'b0; dcWData = '0;
        ioWrite = 1'b0; ioSize = 2'b01; ioAddr = '0; ioWData = '0;
        repeat (3) tick();
        checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", memAddr); end
        checks++; if (readWriteOut !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", readWriteOut); end
        checks++; if (memOut !== 8'h0) begin errors++; $display("FAIL reset_memout got %h want 0", memOut); end
        checks++; if ({ioDone, dcDone, icDone} !== 3'b000) begin errors++; $display("FAIL reset_done got %b want 000", {ioDone, dcDone, icDone}); end
        checks++; if (icData !== '0 || dcRData !== '0) begin errors++; $display("FAIL reset_line got %h want 0", icData); end
        checks++; if (ioRData !== 32'h0) begin errors++; $display("FAIL reset_iordata got %h want 0", ioRData); end
        // First enabled edge after reset release must already grant.
        salt = 8'h5A;
        resetIn = 1'b0; ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b01; ioAddr = 32'h0000_0123;
        wait_done(2, 50, 1'b0, cyc, re, oth);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL first_grant_latency got %0d want 3", cyc); end
        checks++; if (ioRData !== io_read_model(32'h123, 1)) begin errors++; $display("FAIL first_grant_data got %h want %h", ioRData, io_read_model(32'h123, 1)); end
        drop_all(); tick();
    endtask

    task automatic test_ic_refill();
        int cyc, re, oth;
        salt = 8'h00;
        icTag = 28'h0000100; icReq = 1'b1;
        wait_done(0, 60, 1'b0, cyc, re, oth);
        checks++; if (cyc !== N + 2) begin errors++; $display("FAIL ic_latency got %0d want %0d", cyc, N + 2); end
        checks++; if (icData !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL ic_data got %h want 0f0e..0100", icData); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (addr_trace.size() <= i || addr_trace[i] !== 32'h1000 + 32'(i)) begin
                errors++; $display("FAIL ic_addr[%0d] got %h want %h", i, (addr_trace.size() > i) ? addr_trace[i] : 32'hx, 32'h1000 + 32'(i));
            end
        end
        checks++; if (addr_trace.size() <= N || addr_trace[N] !== 32'h0) begin errors++; $display("FAIL ic_addr_tail got nonzero or missing, want 0"); end
        drop_all(); tick();
    endtask

    task automatic test_io_write();
        int cyc, re, oth;
        logic [39:0] exp_log[4];
        exp_log = '{{32'h30000, 8'hEF}, {32'h30001, 8'hBE}, {32'h30002, 8'hAD}, {32'h30003, 8'hDE}};
        wr_log.delete();
        ioReq = 1'b1; ioWrite = 1'b1; ioSize = 2'b11; ioAddr = 32'h30000; ioWData = 32'hDEADBEEF;
        wait_done(2, 50, 1'b0, cyc, re, oth);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL io_write_latency got %0d want 5", cyc); end
        checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL io_write_count got %0d want 4", wr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log.size() <= i || wr_log[i] !== exp_log[i]) begin
                errors++; $display("FAIL io_write[%0d] got %h want %h", i, (wr_log.size() > i) ? wr_log[i] : 40'hx, exp_log[i]);
            end
        end
        drop_all(); tick();
    endtask

    task automatic test_priority();
        int order[$];
        int when[$];
        int extra = 0;
        int exp_t[3];
        logic [2:0] d;
        salt = 8'h33;
        ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b10; ioAddr = 32'h0000_40FF;
        dcReq = 1'b1; dcWrite = 1'b0; dcTag = 28'h0ABCDE1;
        icReq = 1'b1; icTag = 28'h0123456;
        // Each later grant follows one IDLE cycle after the previous DONE.
        exp_t[0] = 2 + 2;
        exp_t[1] = exp_t[0] + 1 + (N + 2);
        exp_t[2] = exp_t[1] + 1 + (N + 2);
        for (int n = 1; n <= 200 && order.size() < 3; n++) begin
            tick();
            d = {ioDone, dcDone, icDone};
            for (int j = 2; j >= 0; j--) begin
                if (d[j]) begin
                    order.push_back(j); when.push_back(n);
                    if (j == 2) begin
                        ioReq = 1'b0;
                        checks++; if (ioRData !== io_read_model(32'h40FF, 2)) begin errors++; $display("FAIL prio_io_data got %h want %h", ioRData, io_read_model(32'h40FF, 2)); end
                    end else if (j == 1) begin
                        dcReq = 1'b0;
                        checks++; if (dcRData !== line_model({28'h0ABCDE1, 4'h0})) begin errors++; $display("FAIL prio_dc_data got %h want %h", dcRData, line_model({28'h0ABCDE1, 4'h0})); end
                    end else begin
                        icReq = 1'b0;
                        checks++; if (icData !== line_model({28'h0123456, 4'h0})) begin errors++; $display("FAIL prio_ic_data got %h want %h", icData, line_model({28'h0123456, 4'h0})); end
                    end
                end
            end
        end
        for (int n = 0; n < 25; n++) begin
            tick();
            if (ioDone || dcDone || icDone) extra++;
        end
        checks++; if (order.size() !== 3) begin errors++; $display("FAIL prio_count got %0d want 3", order.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (order.size() <= i || order[i] !== 2 - i || when[i] !== exp_t[i]) begin
                errors++; $display("FAIL prio_slot%0d got id %0d at %0d want id %0d at %0d", i,
                    (order.size() > i) ? order[i] : -1, (when.size() > i) ? when[i] : -1, 2 - i, exp_t[i]);
            end
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL prio_extra_done got %0d want 0", extra); end
        drop_all(); tick();
    endtask

    task automatic test_stall();
        int cyc, re, oth;
        logic [31:0] base;
        salt = 8'($urandom);
        dcTag = 28'($urandom); base = {dcTag, 4'h0};
        wr_log.delete();
        dcReq = 1'b1; dcWrite = 1'b0;
        repeat (6) tick();
        checks++; if (memAddr !== base + 32'd5) begin errors++; $display("FAIL stall_pre_addr got %h want %h", memAddr, base + 32'd5); end
        readyIn = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (memAddr !== base + 32'd4 || readWriteOut !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got addr %h rw %b want addr %h rw 0", s, memAddr, readWriteOut, base + 32'd4);
            end
            tick();
        end
        readyIn = 1'b1;
        wait_done(1, 60, 1'b0, cyc, re, oth);
        checks++; if (cyc !== (N + 2) + 3 - 9) begin errors++; $display("FAIL stall_latency got %0d want %0d", cyc, (N + 2) + 3 - 9); end
        checks++; if (dcRData !== line_model(base)) begin errors++; $display("FAIL stall_line got %h want %h", dcRData, line_model(base)); end
        checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL stall_writes got %0d want 0", wr_log.size()); end
        drop_all(); tick();
    endtask

    task automatic test_clear();
        int cyc, re, oth;
        int ic_seen = 0;
        int bad = 0;
        logic [31:0] dbase;
        salt = 8'h77;
        wr_log.delete();
        icTag = 28'h0FACE01; icReq = 1'b1;
        repeat (8) tick();
        clearIn = 1'b1; icReq = 1'b0;
        dcReq = 1'b1; dcWrite = 1'b1; dcTag = 28'h0BEEF02; dcWData = {$urandom, $urandom, $urandom, $urandom};
        dbase = {dcTag, 4'h0};
        tick();
        checks++; if (memAddr !== 32'h0 || icDone !== 1'b0) begin errors++; $display("FAIL clear_abort got addr %h icDone %b want 0 0", memAddr, icDone); end
        clearIn = 1'b0;
        wait_done(1, 60, 1'b0, cyc, re, oth);
        checks++; if (cyc !== N + 1) begin errors++; $display("FAIL clear_dc_latency got %0d want %0d", cyc, N + 1); end
        checks++; if (oth !== 0) begin errors++; $display("FAIL clear_stray_done got %0d want 0", oth); end
        for (int i = 0; i < N; i++)
            if (wr_log.size() <= i || wr_log[i] !== {dbase + 32'(i), dcWData[8*i +: 8]}) bad++;
        checks++; if (wr_log.size() !== N || bad !== 0) begin errors++; $display("FAIL clear_dc_writes got %0d entries %0d bad want %0d entries 0 bad", wr_log.size(), bad, N); end
        drop_all();
        for (int n = 0; n < 20; n++) begin tick(); if (icDone) ic_seen++; end
        checks++; if (ic_seen !== 0) begin errors++; $display("FAIL clear_ic_done got %0d want 0", ic_seen); end
        // A flush in IDLE blocks only the ic grant of that cycle.
        icTag = 28'h0000222; icReq = 1'b1; clearIn = 1'b1;
        tick();
        checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL clear_block_grant got %h want 0", memAddr); end
        clearIn = 1'b0;
        wait_done(0, 60, 1'b0, cyc, re, oth);
        checks++; if (cyc !== N + 2) begin errors++; $display("FAIL clear_block_latency got %0d want %0d", cyc, N + 2); end
        drop_all(); tick();
        // io reads abort, io writes do not.
        ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b11; ioAddr = 32'h500;
        repeat (2) tick();
        clearIn = 1'b1; tick(); clearIn = 1'b0; ioReq = 1'b0;
        oth = 0;
        for (int n = 0; n < 10; n++) begin tick(); if (ioDone) oth++; end
        checks++; if (oth !== 0) begin errors++; $display("FAIL clear_io_read_done got %0d want 0", oth); end
        ioReq = 1'b1; ioWrite = 1'b1; ioSize = 2'b10; ioWData = 32'h0000_A55A; clearIn = 1'b1;
        wait_done(2, 30, 1'b0, cyc, re, oth);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL clear_io_write_latency got %0d want 3", cyc); end
        drop_all(); tick();
    endtask

    task automatic test_reset_mid();
        int n_before;
        int seen = 0;
        wr_log.delete();
        dcReq = 1'b1; dcWrite = 1'b1; dcTag = 28'h0777777; dcWData = {$urandom, $urandom, $urandom, $urandom};
        repeat (5) tick();
        checks++; if (readWriteOut !== 1'b1) begin errors++; $display("FAIL rstmid_writing got %b want 1", readWriteOut); end
        n_before = wr_log.size();
        resetIn = 1'b1;
        #1;
        checks++; if (readWriteOut !== 1'b0 || memAddr !== 32'h0 || memOut !== 8'h0) begin
            errors++; $display("FAIL rstmid_outputs got rw %b addr %h out %h want 0 0 0", readWriteOut, memAddr, memOut);
        end
        repeat (2) tick();
        resetIn = 1'b0; dcReq = 1'b0;
        for (int n = 0; n < 25; n++) begin tick(); if (dcDone) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", seen); end
        checks++; if (wr_log.size() !== n_before) begin errors++; $display("FAIL rstmid_writes got %0d want %0d", wr_log.size(), n_before); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int r, len, lat, cyc, re, oth, bad;
            bit wr;
            logic [31:0] base;
            logic [8*N-1:0] wdata;
            salt = 8'($urandom);
            r = $urandom_range(0, 2);
            wr = 1'b0; bad = 0;
            wdata = {$urandom, $urandom, $urandom, $urandom};
            base = $urandom;
            wr_log.delete();
            case (r)
                0: begin
                    base[3:0] = 4'h0; len = N;
                    icTag = base[31:4]; icReq = 1'b1;
                end
                1: begin
                    base[3:0] = 4'h0; len = N; wr = 1'($urandom);
                    dcTag = base[31:4]; dcWrite = wr; dcWData = wdata; dcReq = 1'b1;
                end
                default: begin
                    ioSize = 2'($urandom_range(1, 3));
                    len = (ioSize == 2'b11) ? 4 : int'(ioSize);
                    wr = 1'($urandom);
                    ioAddr = base; ioWrite = wr; ioWData = wdata[31:0]; ioReq = 1'b1;
                end
            endcase
            lat = wr ? len + 1 : len + 2;
            readyIn = ($urandom_range(0, 3) != 0);
            wait_done(r, 400, 1'b1, cyc, re, oth);
            checks++;
            if (cyc < 0 || re !== lat) begin errors++; $display("FAIL rand%0d_latency got cyc %0d enabled edges %0d want edges %0d", it, cyc, re, lat); end
            checks++;
            if (oth !== 0) begin errors++; $display("FAIL rand%0d_stray_done got %0d want 0", it, oth); end
            checks++;
            if (wr) begin
                for (int i = 0; i < len; i++)
                    if (wr_log.size() <= i || wr_log[i] !== {base + 32'(i), wdata[8*i +: 8]}) bad++;
                if (wr_log.size() !== len || bad !== 0) begin
                    errors++; $display("FAIL rand%0d_writes got %0d entries %0d bad want %0d entries", it, wr_log.size(), bad, len);
                end
            end else if (r == 0) begin
                if (icData !== line_model(base) || wr_log.size() !== 0) begin errors++; $display("FAIL rand%0d_ic got %h want %h", it, icData, line_model(base)); end
            end else if (r == 1) begin
                if (dcRData !== line_model(base) || wr_log.size() !== 0) begin errors++; $display("FAIL rand%0d_dc got %h want %h", it, dcRData, line_model(base)); end
            end else begin
                if (ioRData !== io_read_model(base, len) || wr_log.size() !== 0) begin errors++; $display("FAIL rand%0d_io got %h want %h", it, ioRData, io_read_model(base, len)); end
            end
            drop_all(); tick();
        end
    endtask

    initial begin
        test_reset();
        test_ic_refill();
        test_io_write();
        test_priority();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
